llc_assoc_read_cache: RTL and testbench

Parametrised set-associative, read-only last-level cache. It services line-granular read requests from the upper cache over a valid/ready request/response pair, and refills misses from memory with a single AXI4 INCR burst per line. It generalises the direct-mapped read LLC with configurable ways, AXI data width, a victim policy, error reporting and an invalidate-all operation.

---
 rtl/llc_assoc_read_cache.sv | 217 +++++++++++++++++++++
 tb/tb_llc_assoc_read_cache.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/llc_assoc_read_cache.sv
// Set-associative read-only last-level cache: line-granular lookups, one AXI4
// INCR burst per miss, lowest-invalid/round-robin victim choice, invalidate-all.
module llc_assoc_read_cache #(
    parameter int LINE_COUNT     = 64,
    parameter int WAYS           = 2,
    parameter int BYTES_PER_LINE = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       s_r_addr,
    input  logic                        s_r_addr_valid,
    output logic                        s_r_addr_ready,
    output logic [BYTES_PER_LINE*8-1:0] s_r_data,
    output logic                        s_r_data_valid,
    input  logic                        s_r_data_ready,
    output logic                        s_r_err,
    input  logic                        inv_all,
    output logic                        inv_busy,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);
    localparam int BEATS  = BYTES_PER_LINE * 8 / AXI_DATA_WIDTH;
    localparam int OFFSET = $clog2(BYTES_PER_LINE);
    localparam int INDEX  = $clog2(LINE_COUNT);
    localparam int TAG_W  = ADDR_WIDTH - INDEX - OFFSET;
    localparam int LINE_W = BYTES_PER_LINE * 8;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = BEAT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_REQUEST, ST_FILL, ST_RESPOND, ST_INVALIDATE
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [INDEX-1:0]          inv_cnt_r;
    logic                      err_r, inv_pend_r;
    logic [LINE_W-1:0]         resp_data_r;
    logic [WAYS-1:0]           valid_r   [LINE_COUNT];
    logic [WAY_W-1:0]          rr_r      [LINE_COUNT];
    logic [TAG_W-1:0]          tag_mem_r [LINE_COUNT][WAYS];
    logic [LINE_W-1:0]         data_mem_r[LINE_COUNT][WAYS];
    logic [AXI_DATA_WIDTH-1:0] fill_buf_r[BEATS];

    logic [INDEX-1:0]  set_s;
    logic [TAG_W-1:0]  tag_s;
    logic              hit_s, set_full_s, fill_err_s, install_s, beat_s;
    logic [WAY_W-1:0]  hit_way_s, victim_s;
    logic [LINE_W-1:0] line_s;

    assign set_s = addr_r[OFFSET +: INDEX];
    assign tag_s = addr_r[OFFSET+INDEX +: TAG_W];

    // Tag compare across the set, and victim choice (lowest invalid way wins over the pointer)
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = '0;
        victim_s   = rr_r[set_s];
        set_full_s = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s  = (valid_r[set_s][w] && tag_mem_r[set_s][w] == tag_s) ? WAY_W'(w) : hit_way_s;
            hit_s      = hit_s | (valid_r[set_s][w] && tag_mem_r[set_s][w] == tag_s);
            victim_s   = valid_r[set_s][w] ? victim_s : WAY_W'(w);
            set_full_s = set_full_s & valid_r[set_s][w];
        end
    end

    // Fill beat qualification and the assembled line including the beat on the bus
    always_comb begin
        beat_s     = (state_r == ST_FILL) && m_axi_rvalid;
        fill_err_s = err_r | (m_axi_rresp != 2'b00) | (m_axi_rlast && cnt_r != CNT_W'(BEATS - 1));
        install_s  = beat_s && m_axi_rlast && !fill_err_s;
        line_s     = '0;
        for (int b = 0; b < BEATS; b++) begin
            line_s[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
                (cnt_r == CNT_W'(b)) ? m_axi_rdata : fill_buf_r[b];
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (inv_all || inv_pend_r) begin
                    state_nxt_s = ST_INVALIDATE;
                end else if (s_r_addr_valid) begin
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP:     state_nxt_s = hit_s ? ST_RESPOND : ST_REQUEST;
            ST_REQUEST:    state_nxt_s = m_axi_arready ? ST_FILL : ST_REQUEST;
            ST_FILL:       state_nxt_s = (m_axi_rvalid && m_axi_rlast) ? ST_RESPOND : ST_FILL;
            ST_RESPOND:    state_nxt_s = s_r_data_ready ? ST_IDLE : ST_RESPOND;
            ST_INVALIDATE: state_nxt_s = (inv_cnt_r == INDEX'(LINE_COUNT - 1)) ? ST_IDLE : ST_INVALIDATE;
            default:       state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state, valid bits, victim pointers and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            cnt_r       <= '0;
            inv_cnt_r   <= '0;
            err_r       <= 1'b0;
            inv_pend_r  <= 1'b0;
            resp_data_r <= '0;
            for (int i = 0; i < LINE_COUNT; i++) begin
                valid_r[i] <= '0;
                rr_r[i]    <= '0;
            end
        end else begin
            state_r <= state_nxt_s;
            // Pulses outside IDLE collapse into one pending request; INVALIDATE already covers them
            if (state_r == ST_IDLE && (inv_all || inv_pend_r)) begin
                inv_pend_r <= 1'b0;
            end else if (inv_all && state_r != ST_IDLE && state_r != ST_INVALIDATE) begin
                inv_pend_r <= 1'b1;
            end else begin
                inv_pend_r <= inv_pend_r;
            end
            case (state_r)
                ST_IDLE: begin
                    inv_cnt_r <= '0;
                    if (!(inv_all || inv_pend_r) && s_r_addr_valid) begin
                        addr_r <= s_r_addr;
                    end
                end
                ST_LOOKUP: begin
                    resp_data_r <= data_mem_r[set_s][hit_way_s];
                    err_r       <= 1'b0;
                    cnt_r       <= '0;
                end
                ST_FILL: begin
                    if (beat_s) begin
                        cnt_r <= (cnt_r == CNT_W'(BEATS)) ? cnt_r : cnt_r + CNT_W'(1);
                        err_r <= fill_err_s;
                        if (m_axi_rlast) begin
                            resp_data_r <= line_s;
                        end
                        if (install_s) begin
                            valid_r[set_s][victim_s] <= 1'b1;
                            if (set_full_s) begin
                                rr_r[set_s] <= (WAYS == 1) ? '0 : rr_r[set_s] + WAY_W'(1);
                            end
                        end
                    end
                end
                ST_INVALIDATE: begin
                    valid_r[inv_cnt_r] <= '0;
                    rr_r[inv_cnt_r]    <= '0;
                    inv_cnt_r          <= inv_cnt_r + INDEX'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Line storage and fill buffer carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (beat_s && cnt_r < CNT_W'(BEATS)) begin
            fill_buf_r[cnt_r[BEAT_W-1:0]] <= m_axi_rdata;
        end
        if (install_s) begin
            tag_mem_r[set_s][victim_s]  <= tag_s;
            data_mem_r[set_s][victim_s] <= line_s;
        end
    end

    // Outputs decoded from state and registers, forced low while reset is held
    always_comb begin
        s_r_addr_ready = 1'b0;
        s_r_data       = '0;
        s_r_data_valid = 1'b0;
        s_r_err        = 1'b0;
        inv_busy       = 1'b0;
        m_axi_araddr   = '0;
        m_axi_arlen    = 8'd0;
        m_axi_arsize   = 3'd0;
        m_axi_arburst  = 2'b00;
        m_axi_arvalid  = 1'b0;
        m_axi_rready   = 1'b0;
        if (reset) begin
            s_r_addr_ready = 1'b0;
        end else begin
            s_r_addr_ready = (state_r == ST_IDLE) && !inv_pend_r;
            s_r_data       = resp_data_r;
            s_r_data_valid = (state_r == ST_RESPOND);
            s_r_err        = err_r;
            inv_busy       = inv_pend_r || (state_r == ST_INVALIDATE);
            m_axi_araddr   = addr_r & ~ADDR_WIDTH'(BYTES_PER_LINE - 1);
            m_axi_arlen    = 8'(BEATS - 1);
            m_axi_arsize   = 3'($clog2(AXI_DATA_WIDTH / 8));
            m_axi_arburst  = 2'b01;
            m_axi_arvalid  = (state_r == ST_REQUEST);
            m_axi_rready   = (state_r == ST_FILL);
        end
    end
endmodule

// File: tb/tb_llc_assoc_read_cache.sv
// Directed bench for llc_assoc_read_cache: a bench-driven AXI slave returns
// base+beat per line; expected lines, latencies and AR fields are hand-derived.
module tb_llc_assoc_read_cache;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  s_r_addr = 64'd0;
    logic         s_r_addr_valid = 1'b0;
    logic         s_r_addr_ready;
    logic [511:0] s_r_data;
    logic         s_r_data_valid;
    logic         s_r_data_ready = 1'b0;
    logic         s_r_err;
    logic         inv_all = 1'b0;
    logic         inv_busy;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [63:0]  m_axi_rdata = 64'd0;
    logic [1:0]   m_axi_rresp = 2'b00;
    logic         m_axi_rlast = 1'b0;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;

    int tests_run = 0;
    int tests_failed = 0;

    llc_assoc_read_cache dut (
        .clk(clk), .reset(reset),
        .s_r_addr(s_r_addr), .s_r_addr_valid(s_r_addr_valid), .s_r_addr_ready(s_r_addr_ready),
        .s_r_data(s_r_data), .s_r_data_valid(s_r_data_valid), .s_r_data_ready(s_r_data_ready),
        .s_r_err(s_r_err), .inv_all(inv_all), .inv_busy(inv_busy),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return (addr[63:6] == 58'h40) ? 64'd0 : ({addr[47:0], 16'h0} + 64'hA000_0000);
    endfunction

    function automatic logic [511:0] exp_line(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
        return l;
    endfunction

    // mode 0: clean 8-beat fill; 1: SLVERR on beat 3; 2: rlast on beat 5
    task automatic do_read(input logic [63:0] addr, input int mode, input bit inv_pulse,
                           output logic [511:0] data, output logic err, output int lat, output bit saw_ar);
        int  beat;
        int  last;
        bit  got;
        bit  inv_chk;
        logic [63:0] base;
        beat = 0; got = 1'b0; inv_chk = 1'b0; saw_ar = 1'b0; lat = 0; data = '0; err = 1'b0;
        last = (mode == 2) ? 5 : 7;
        base = line_base(addr);
        for (int k = 0; k < 200 && !s_r_addr_ready; k++) @(negedge clk);
        if (!s_r_addr_ready) check("addr_ready_timeout", 0, 1);
        s_r_addr = addr;
        s_r_addr_valid = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            s_r_addr_valid = 1'b0;
            inv_all = 1'b0;
            if (inv_chk) begin
                check("inv_busy_during_fill", inv_busy, 1);
                inv_chk = 1'b0;
            end
            if (s_r_data_valid) begin
                data = s_r_data; err = s_r_err; lat = cyc; got = 1'b1;
                m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                break;
            end
            m_axi_arready = 1'b0;
            if (m_axi_arvalid && !saw_ar) begin
                saw_ar = 1'b1;
                check("araddr", m_axi_araddr, {addr[63:6], 6'd0});
                check("arlen", m_axi_arlen, 7);
                check("arsize", m_axi_arsize, 3);
                check("arburst", m_axi_arburst, 1);
                m_axi_arready = 1'b1;
            end
            if (m_axi_rready && beat <= last) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = base + 64'(beat);
                m_axi_rresp  = (mode == 1 && beat == 3) ? 2'b10 : 2'b00;
                m_axi_rlast  = (beat == last);
                if (inv_pulse && beat == 2) begin
                    inv_all = 1'b1;
                    inv_chk = 1'b1;
                end
                beat++;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
        end
        if (!got) check("resp_timeout", 0, 1);
    endtask

    task automatic finish_resp();
        s_r_data_ready = 1'b1;
        @(negedge clk);
        s_r_data_ready = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [63:0] addr, input int mode,
                               input bit exp_ar, input bit exp_err);
        logic [511:0] d; logic e; int l; bit ar;
        do_read(addr, mode, 1'b0, d, e, l, ar);
        check({tag, "_ar"}, ar, exp_ar);
        check({tag, "_err"}, e, exp_err);
        if (!exp_err) check({tag, "_data"}, d, exp_line(line_base(addr)));
        if (!exp_err) check({tag, "_lat"}, l, exp_ar ? 11 : 2);
        finish_resp();
    endtask

    task automatic invalidate_idle();
        int k;
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        check("inv_busy_idle", inv_busy, 1);
        for (k = 0; k < 200 && inv_busy; k++) @(negedge clk);
        check("inv_idle_done", inv_busy, 0);
        check("inv_idle_ready", s_r_addr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        logic         e;
        int           l;
        int           zc;
        bit           ar;
        bit           stable;

        repeat (3) @(negedge clk);
        check("rst_addr_ready", s_r_addr_ready, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_data_valid", s_r_data_valid, 0);
        check("rst_inv_busy", inv_busy, 0);
        check("rst_rready", m_axi_rready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", s_r_addr_ready, 1);

        read_expect("cold_1000", 64'h1000, 0, 1'b1, 1'b0);
        read_expect("hit_1008", 64'h1008, 0, 1'b0, 1'b0);

        // Invalidate raised mid-fill: fill still completes, then the invalidate runs
        do_read(64'h1040, 0, 1'b1, d, e, l, ar);
        check("invfill_err", e, 0);
        check("invfill_data", d, exp_line(line_base(64'h1040)));
        finish_resp();
        zc = 0;
        for (int k = 0; k < 200 && !s_r_addr_ready; k++) begin
            zc++;
            @(negedge clk);
        end
        check("inv_ready_low_cycles", (zc >= 64 && zc <= 65), 1);
        check("inv_busy_cleared", inv_busy, 0);
        read_expect("after_inv_1000", 64'h1000, 0, 1'b1, 1'b0);

        invalidate_idle();
        read_expect("ev_0000", 64'h0000, 0, 1'b1, 1'b0);
        read_expect("ev_1000", 64'h1000, 0, 1'b1, 1'b0);
        read_expect("ev_2000", 64'h2000, 0, 1'b1, 1'b0);
        read_expect("ev_1000_hit", 64'h1000, 0, 1'b0, 1'b0);
        read_expect("ev_0000_miss", 64'h0000, 0, 1'b1, 1'b0);
        read_expect("ev_2000_hit", 64'h2000, 0, 1'b0, 1'b0);
        read_expect("ev_1000_miss", 64'h1000, 0, 1'b1, 1'b0);

        read_expect("slverr_3080", 64'h3080, 1, 1'b1, 1'b1);
        read_expect("slverr_reread", 64'h3080, 0, 1'b1, 1'b0);
        read_expect("early_last_4100", 64'h4100, 2, 1'b1, 1'b1);
        read_expect("early_reread", 64'h4100, 0, 1'b1, 1'b0);

        // Back-pressured response must hold while a new request waits
        do_read(64'h4100, 0, 1'b0, d, e, l, ar);
        check("hold_hit_lat", l, 2);
        stable = 1'b1;
        s_r_addr = 64'h1000;
        s_r_addr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!s_r_data_valid || s_r_data !== exp_line(line_base(64'h4100)) || s_r_err || s_r_addr_ready)
                stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        s_r_addr_valid = 1'b0;
        finish_resp();
        check("hold_release_ready", s_r_addr_ready, 1);
        check("hold_release_valid", s_r_data_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
